regfile_writeback: RTL and testbench

//  Write-side front end of the register file: merges result streams from the single-cycle ALU path
//  and the variable-latency load/store unit into the regfile's single write port
//  (write_enable/address3/write_data). Buffers LSU results in a small FIFO.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back front end.
// Result bundle, default widths and arbiter source encoding.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;
   localparam int WB_FIFO_D = 4;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of write-back requests.
// Push is refused when full; pop is ignored when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int DEPTH = WB_FIFO_D,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  wb_req_t       push_req_i,
   input  logic          pop_i,
   output wb_req_t       head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   wb_req_t       mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_d  = wr_q + PW'(do_push);
      rd_d  = rd_q + PW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= push_req_i;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter for the register file: ALU path, buffered LSU
// results, registered write port and RAW pending scoreboard.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter  int DATA_WIDTH     = WB_DATA_W,
   parameter  int ADDR_WIDTH     = WB_ADDR_W,
   parameter  int LSU_FIFO_DEPTH = WB_FIFO_D,
   localparam int NREG           = 2 ** ADDR_WIDTH,
   localparam int CW             = $clog2(LSU_FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic [NREG-1:0]       pending_mask,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] address3,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [CW-1:0]         fifo_count
);

   wb_req_t lsu_req;
   wb_req_t alu_req;
   wb_req_t head;
   wb_req_t win;
   wb_src_e src;
   logic    fifo_full;
   logic    fifo_empty;
   logic    fifo_pop;

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [NREG-1:0]       pend_q, pend_d;

   assign lsu_req.rd   = lsu_rd;
   assign lsu_req.data = lsu_data;
   assign alu_req.rd   = alu_rd;
   assign alu_req.data = alu_data;

   wb_fifo #(
      .DEPTH (LSU_FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (lsu_valid),
      .push_req_i (lsu_req),
      .pop_i      (fifo_pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign lsu_ready = !fifo_full;

   // A full buffer preempts the ALU so the LSU can never deadlock.
   always_comb begin
      src       = WB_NONE;
      alu_ready = 1'b0;
      fifo_pop  = 1'b0;
      priority case (1'b1)
         fifo_full: begin
            src      = WB_LSU;
            fifo_pop = 1'b1;
         end
         alu_valid: begin
            src       = WB_ALU;
            alu_ready = 1'b1;
         end
         !fifo_empty: begin
            src      = WB_LSU;
            fifo_pop = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      win    = (src == WB_ALU) ? alu_req : head;
      we_d   = (src != WB_NONE) && (win.rd != '0);
      addr_d = (src != WB_NONE) ? win.rd : addr_q;
      data_d = (src != WB_NONE) ? win.data : data_q;
   end

   // New issue beats the retiring write on the same register.
   always_comb begin
      pend_d = pend_q;
      if (we_q) begin
         pend_d[addr_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
         pend_d[issue_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         pend_q <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

   assign write_enable = we_q;
   assign address3     = addr_q;
   assign write_data   = data_q;
   assign pending_mask = pend_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with an expected-write queue
// drained by an independent write-port monitor.
module tb_regfile_writeback;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [31:0] pending_mask;
   logic        write_enable;
   logic [4:0]  address3;
   logic [31:0] write_data;
   logic [2:0]  fifo_count;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   regfile_writeback dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .pending_mask (pending_mask),
      .write_enable (write_enable),
      .address3     (address3),
      .write_data   (write_data),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write-port monitor: every regfile write must match the queue head.
   always @(negedge clk) begin
      if (write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_write: got x%0d=%h, expected no write",
                     address3, write_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_addr", 64'(address3), 64'(e.rd));
            chk("wb_data", 64'(write_data), 64'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_alu(input logic v, input logic [4:0] rd,
                          input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic drv_lsu(input logic v, input logic [4:0] rd,
                          input logic [31:0] d);
      lsu_valid = v;
      lsu_rd    = rd;
      lsu_data  = d;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.rd   = rd;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drv_alu(0, 0, 0);
      drv_lsu(0, 0, 0);
      issue_valid = 1'b0;
      issue_rd    = '0;
      tick();
      tick();

      // Reset with random inputs present
      drv_alu(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      drv_lsu(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      issue_valid = 1'b1;
      issue_rd    = 5'($urandom_range(1, 31));
      tick();
      chk("rst_we", 64'(write_enable), 64'd0);
      chk("rst_addr", 64'(address3), 64'd0);
      chk("rst_data", 64'(write_data), 64'd0);
      chk("rst_mask", 64'(pending_mask), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("rst_alu_ready", 64'(alu_ready), 64'(alu_valid));
      drv_alu(0, 0, 0);
      drv_lsu(0, 0, 0);
      issue_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // ALU only
      drv_alu(1, 5'd5, 32'hDEADBEEF);
      expect_wr(5'd5, 32'hDEADBEEF);
      #1;
      chk("alu_ready_single", 64'(alu_ready), 64'd1);
      tick();
      drv_alu(0, 0, 0);
      chk("alu_we_next", 64'(write_enable), 64'd1);
      tick();
      tick();

      // Contention: ALU first, LSU one cycle later
      drv_alu(1, 5'd3, 32'h11);
      drv_lsu(1, 5'd4, 32'h22);
      expect_wr(5'd3, 32'h11);
      expect_wr(5'd4, 32'h22);
      tick();
      drv_alu(0, 0, 0);
      drv_lsu(0, 0, 0);
      chk("cont_count", 64'(fifo_count), 64'd1);
      tick();
      tick();
      chk("cont_drained", 64'(fifo_count), 64'd0);

      // FIFO fills while the ALU streams
      for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'hA0 + i);
      expect_wr(5'd20, 32'hB0);
      expect_wr(5'd14, 32'hA4);
      for (int i = 1; i < 5; i++) expect_wr(5'(20 + i), 32'hB0 + i);
      for (int i = 0; i < 4; i++) begin
         drv_alu(1, 5'(10 + i), 32'hA0 + i);
         drv_lsu(1, 5'(20 + i), 32'hB0 + i);
         tick();
         chk("fill_count", 64'(fifo_count), 64'(i + 1));
      end
      drv_alu(1, 5'd14, 32'hA4);
      drv_lsu(1, 5'd24, 32'hB4);
      #1;
      chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("full_alu_ready", 64'(alu_ready), 64'd0);
      tick();
      chk("pop_count", 64'(fifo_count), 64'd3);
      chk("resume_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      drv_alu(0, 0, 0);
      drv_lsu(0, 0, 0);
      chk("refill_count", 64'(fifo_count), 64'd4);
      repeat (6) tick();
      chk("full_drained", 64'(fifo_count), 64'd0);

      // Writes to x0 are consumed silently
      drv_alu(1, 5'd0, 32'h1);
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      #1;
      chk("x0_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      drv_alu(0, 0, 0);
      issue_valid = 1'b0;
      chk("x0_we", 64'(write_enable), 64'd0);
      chk("x0_mask", 64'(pending_mask), 64'd0);
      tick();

      // Scoreboard: re-issue on the retiring cycle keeps the bit
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      tick();
      issue_valid = 1'b0;
      chk("sb_set", 64'(pending_mask), 64'h80);
      drv_alu(1, 5'd7, 32'h77);
      expect_wr(5'd7, 32'h77);
      tick();
      drv_alu(0, 0, 0);
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      tick();
      issue_valid = 1'b0;
      chk("sb_set_wins", 64'(pending_mask), 64'h80);
      drv_alu(1, 5'd7, 32'h78);
      expect_wr(5'd7, 32'h78);
      tick();
      drv_alu(0, 0, 0);
      tick();
      chk("sb_clear", 64'(pending_mask), 64'd0);

      // Reset discards buffered LSU results
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      for (int i = 0; i < 3; i++) begin
         drv_alu(1, 5'd0, 32'(i));
         drv_lsu(1, 5'(9 + i), 32'hC0 + i);
         tick();
         issue_valid = 1'b0;
      end
      chk("flush_pre_count", 64'(fifo_count), 64'd3);
      chk("flush_pre_mask", 64'(pending_mask), 64'h200);
      drv_alu(0, 0, 0);
      drv_lsu(0, 0, 0);
      rst_n = 1'b0;
      tick();
      chk("flush_count", 64'(fifo_count), 64'd0);
      chk("flush_mask", 64'(pending_mask), 64'd0);
      chk("flush_we", 64'(write_enable), 64'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("post_flush_count", 64'(fifo_count), 64'd0);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
